// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single valid/ready memory bus,
// with an optional BUSY timeout that force-completes the owner with an error.

module mem_arbiter_port (
   input  logic        sel,
   input  logic        done,
   input  logic        err,
   input  logic [31:0] s_rdata,
   output logic        ready,
   output logic [31:0] rdata
);
   assign ready = sel & done;
   assign rdata = !ready ? 32'h0 : (err ? 32'hFFFF_FFFF : s_rdata);
endmodule

module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        bus_err
);
   localparam int          NUM_REQ = 2;
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   req_t [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        vld;
   logic [NUM_REQ-1:0]        rdy;
   logic [NUM_REQ-1:0][31:0]  rd;
   state_t                    state, state_nxt;
   logic                      owner, owner_nxt;
   logic                      last, last_nxt;
   logic [31:0]               cnt, cnt_nxt;
   logic [1:0]                rst_sync;
   logic                      arb_en, busy, own_vld, to_hit, done, err;

   assign req[0] = {m0_addr, m0_wdata, m0_wstrb};
   assign req[1] = {m1_addr, m1_wdata, m1_wstrb};
   assign vld    = {m1_valid, m0_valid};

   // Release is re-timed so no grant can be taken on the edge that sees resetn rise.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end
   assign arb_en = rst_sync[1];

   assign busy    = (state == BUSY);
   assign own_vld = vld[owner];
   assign to_hit  = (TIMEOUT != 0) && (cnt == TO_LAST);
   assign done    = busy && own_vld && (s_ready || to_hit);
   assign err     = busy && own_vld && !s_ready && to_hit;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= 32'h0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (arb_en && (|vld)) begin
               owner_nxt = (&vld) ? ~last : vld[1];
               state_nxt = BUSY;
               cnt_nxt   = 32'h0;
            end
         end
         BUSY: begin
            // A dropped request is abandoned without touching fairness history.
            if (!own_vld) begin
               state_nxt = IDLE;
            end else if (done) begin
               state_nxt = IDLE;
               last_nxt  = owner;
            end else if (cnt != 32'hFFFF_FFFF) begin
               cnt_nxt   = cnt + 32'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_valid = 1'b0;
      s_addr  = 32'h0;
      s_wdata = 32'h0;
      s_wstrb = 4'h0;
      grant   = 2'b00;
      bus_err = 1'b0;
      if (busy) begin
         s_valid = own_vld;
         s_addr  = req[owner].addr;
         s_wdata = req[owner].wdata;
         s_wstrb = req[owner].wstrb;
         grant   = owner ? 2'b10 : 2'b01;
         bus_err = err;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_port
      localparam logic ID = 1'(g);
      mem_arbiter_port u_port (
         .sel     (owner == ID),
         .done    (done),
         .err     (err),
         .s_rdata (s_rdata),
         .ready   (rdy[g]),
         .rdata   (rd[g])
      );
   end

   assign m0_ready = rdy[0];
   assign m1_ready = rdy[1];
   assign m0_rdata = rd[0];
   assign m1_rdata = rd[1];
endmodule
